regbank_wb_arbiter: RTL and testbench

- Shares the single register-bank write port between two writeback requesters: ALU result (req 0) and load result (req 1).
- Arbitrates round-robin and registers the winning write for one cycle before driving the bank write port.
- Keeps a pending-write scoreboard so that issue logic can stall on RAW hazards against in-flight destination registers.

---
 rtl/regbank_wb_arbiter_if.sv | 47 ++++
 rtl/regbank_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regbank_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_wb_arbiter_if.sv
// Writeback bundle: ALU/load requesters, destination reservation and hazard check, bank write port.
interface regbank_wb_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
);
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            mem_valid;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;

  logic            rsv_valid;
  logic [AW-1:0]   rsv_rd;
  logic [AW-1:0]   chk_rs1;
  logic [AW-1:0]   chk_rs2;
  logic            hazard;

  logic             reg_write;
  logic [AW-1:0]    rd;
  logic [XLEN-1:0]  write_data;
  logic [NREGS-1:0] pend_mask;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  rsv_valid, rsv_rd, chk_rs1, chk_rs2,
    output hazard,
    output reg_write, rd, write_data, pend_mask
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output rsv_valid, rsv_rd, chk_rs1, chk_rs2,
    input  hazard,
    input  reg_write, rd, write_data, pend_mask
  );
endinterface

// File: rtl/regbank_wb_arbiter.sv
// Round-robin ALU/load writeback arbiter with one registered write stage and a pending-write scoreboard.
// Accept in N, bank write in N+1; ready is combinational from valids and the priority pointer.
module regbank_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic               clk,
  input  logic               rst,
  regbank_wb_arbiter_if.slave bus
);

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_t;

  pri_t             pri_q;
  pri_t             pri_d;
  logic             grant_alu;
  logic             grant_mem;

  logic             wr_q;
  logic [AW-1:0]    rd_q;
  logic [XLEN-1:0]  data_q;
  logic             wr_out;

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_set;
  logic [NREGS-1:0] pend_clr;

  // Priority pointer: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= PRI_ALU;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Priority pointer: next state, flips to the other side after any grant
  always_comb begin
    pri_d = pri_q;
    if (grant_alu) begin
      pri_d = PRI_MEM;
    end else if (grant_mem) begin
      pri_d = PRI_ALU;
    end
  end

  // Grant outputs; nothing is accepted while reset is asserted
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst) begin
      grant_alu = bus.alu_valid && (!bus.mem_valid || pri_q == PRI_ALU);
      grant_mem = bus.mem_valid && (!bus.alu_valid || pri_q == PRI_MEM);
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;

  // Write stage; rd=0 requests are consumed without producing a bank write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wr_q <= 1'b0;
      if (grant_alu && bus.alu_rd != '0) begin
        wr_q   <= 1'b1;
        rd_q   <= bus.alu_rd;
        data_q <= bus.alu_data;
      end else if (grant_mem && bus.mem_rd != '0) begin
        wr_q   <= 1'b1;
        rd_q   <= bus.mem_rd;
        data_q <= bus.mem_data;
      end
    end
  end

  // A write still in the stage when reset arrives is dropped, not retired
  assign wr_out = wr_q & ~rst;

  assign bus.reg_write  = wr_out;
  assign bus.rd         = rd_q;
  assign bus.write_data = data_q;

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (bus.rsv_valid) begin
      pend_set[bus.rsv_rd] = 1'b1;
    end
    if (wr_out) begin
      pend_clr[rd_q] = 1'b1;
    end
    pend_set[0] = 1'b0;
  end

  // Set after clear so a new reservation survives the retiring write
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~pend_clr) | pend_set;
    end
  end

  assign bus.pend_mask = pend_q;
  assign bus.hazard    = pend_q[bus.chk_rs1] | pend_q[bus.chk_rs2];

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Bench for regbank_wb_arbiter: directed scenarios plus held-request random traffic against a behavioural model.
module tb_regbank_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regbank_wb_arbiter_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) bus ();

  regbank_wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests;
  int n_fail;

  // Model: pending set per register, who won last, and the write due on the bank next cycle
  bit              m_pend [NREGS];
  int              m_last;
  bit              m_wv;
  int              m_wrd;
  logic [XLEN-1:0] m_wdat;
  bit              alu_taken;
  bit              mem_taken;
  int              seen [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
    m_last = 1;
    m_wv   = 1'b0;
    m_wrd  = 0;
    m_wdat = '0;
  endtask

  // -1 none, 0 ALU, 1 load; on contention the side that did not win last time goes
  function automatic int winner();
    if (rst) return -1;
    if (bus.alu_valid && bus.mem_valid) return (m_last == 0) ? 1 : 0;
    if (bus.alu_valid) return 0;
    if (bus.mem_valid) return 1;
    return -1;
  endfunction

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_rd    = '0;
    bus.chk_rs1   = '0;
    bus.chk_rs2   = '0;
  endtask

  // Check every output mid-cycle, then advance the model at the clock edge
  task automatic cycle();
    logic [NREGS-1:0] ep;
    int w;
    @(negedge clk);
    w = winner();
    for (int i = 0; i < NREGS; i++) ep[i] = m_pend[i];
    check("alu_ready", 64'(bus.alu_ready), 64'(w == 0));
    check("mem_ready", 64'(bus.mem_ready), 64'(w == 1));
    check("reg_write", 64'(bus.reg_write), 64'(m_wv && !rst));
    check("rd", 64'(bus.rd), 64'(m_wrd));
    check("write_data", 64'(bus.write_data), 64'(m_wdat));
    check("pend_mask", 64'(bus.pend_mask), 64'(ep));
    check("hazard", 64'(bus.hazard), 64'(m_pend[bus.chk_rs1] || m_pend[bus.chk_rs2]));
    if (bus.reg_write) seen.push_back(int'(bus.rd));
    @(posedge clk);
    alu_taken = (w == 0);
    mem_taken = (w == 1);
    if (rst) begin
      model_reset();
    end else begin
      if (m_wv) m_pend[m_wrd] = 1'b0;
      if (bus.rsv_valid && bus.rsv_rd != 0) m_pend[bus.rsv_rd] = 1'b1;
      if (w >= 0) m_last = w;
      m_wv = 1'b0;
      if (w == 0 && bus.alu_rd != 0) begin
        m_wv = 1'b1; m_wrd = int'(bus.alu_rd); m_wdat = bus.alu_data;
      end else if (w == 1 && bus.mem_rd != 0) begin
        m_wv = 1'b1; m_wrd = int'(bus.mem_rd); m_wdat = bus.mem_data;
      end
    end
    #1;
  endtask

  initial begin
    int a;
    int m;
    int guard;
    int exp_order [8];
    n_tests = 0;
    n_fail  = 0;
    exp_order = '{1, 9, 2, 10, 3, 11, 4, 12};

    // Reset with both requesters asking
    idle();
    rst = 1'b1;
    bus.alu_valid = 1'b1;
    bus.mem_valid = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("post_rst_alu_first", 64'(alu_taken), 64'(1));
    idle();
    cycle();

    // Lone ALU write and its one-cycle latency
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    cycle();
    idle();
    check("lat_wr", 64'(bus.reg_write), 64'(1));
    check("lat_rd", 64'(bus.rd), 64'(5));
    check("lat_data", 64'(bus.write_data), 64'(32'hDEADBEEF));
    cycle();
    check("lat_wr_drop", 64'(bus.reg_write), 64'(0));

    // Reservation, hazard until the retiring write has passed the bank
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd7;
    bus.chk_rs1   = 5'd7;
    cycle();
    bus.rsv_valid = 1'b0;
    check("haz_set", 64'(bus.hazard), 64'(1));
    cycle();
    cycle();
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd7;
    bus.mem_data  = 32'hCAFE0007;
    cycle();
    bus.mem_valid = 1'b0;
    check("haz_hold_wr", 64'(bus.hazard), 64'(1));
    cycle();
    check("haz_clear", 64'(bus.hazard), 64'(0));
    check("pend7_clear", 64'(bus.pend_mask[7]), 64'(0));

    // Reserve the register whose write is retiring this cycle
    idle();
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd3;
    cycle();
    bus.rsv_valid = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'h33;
    cycle();
    bus.alu_valid = 1'b0;
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd3;
    bus.chk_rs2   = 5'd3;
    cycle();
    bus.rsv_valid = 1'b0;
    check("set_wins_pend3", 64'(bus.pend_mask[3]), 64'(1));
    check("set_wins_haz", 64'(bus.hazard), 64'(1));

    // Register 0 is consumed silently
    bus.alu_valid = 1'b1;
    bus.alu_rd    = '0;
    bus.alu_data  = 32'h1234;
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = '0;
    cycle();
    idle();
    check("r0_no_write", 64'(bus.reg_write), 64'(0));
    check("r0_pend", 64'(bus.pend_mask[0]), 64'(0));

    // Sustained contention from a fresh pointer
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    seen.delete();
    a = 1;
    m = 9;
    guard = 0;
    while ((a <= 4 || m <= 12) && guard < 20) begin
      bus.alu_valid = (a <= 4);
      bus.alu_rd    = AW'(a);
      bus.alu_data  = XLEN'(a * 16);
      bus.mem_valid = (m <= 12);
      bus.mem_rd    = AW'(m);
      bus.mem_data  = XLEN'(m * 16);
      cycle();
      if (alu_taken) a++;
      if (mem_taken) m++;
      guard++;
    end
    check("rr_done_in_8", 64'(guard), 64'(8));
    idle();
    cycle();
    cycle();
    check("rr_count", 64'(seen.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < seen.size()) check("rr_order", 64'(seen[i]), 64'(exp_order[i]));
    end

    // Reset lands on an accepted-but-unwritten load
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd8;
    bus.mem_data  = 32'h88;
    bus.rsv_valid = 1'b1;
    bus.rsv_rd    = 5'd8;
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_drop_wr", 64'(bus.reg_write), 64'(0));
    check("rst_pend", 64'(bus.pend_mask), 64'(0));
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd2;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd4;
    cycle();
    check("rst_ptr_alu", 64'(alu_taken), 64'(1));
    idle();

    // Random traffic; a request not yet accepted keeps its rd and data
    for (int n = 0; n < 3000; n++) begin
      if (!(bus.alu_valid && !alu_taken)) begin
        bus.alu_valid = ($urandom_range(0, 2) != 0);
        bus.alu_rd    = AW'($urandom_range(0, 7));
        bus.alu_data  = XLEN'($urandom);
      end
      if (!(bus.mem_valid && !mem_taken)) begin
        bus.mem_valid = ($urandom_range(0, 2) != 0);
        bus.mem_rd    = AW'($urandom_range(0, 7));
        bus.mem_data  = XLEN'($urandom);
      end
      bus.rsv_valid = ($urandom_range(0, 3) == 0);
      bus.rsv_rd    = AW'($urandom_range(0, 7));
      bus.chk_rs1   = AW'($urandom_range(0, 7));
      bus.chk_rs2   = AW'($urandom_range(0, NREGS - 1));
      rst           = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
